// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vram_arb_pkg
// Desc     : Shared grant encoding and default geometry for the VRAM arbiter.
// Revision : 1.0
// ============================================================================
package vram_arb_pkg;

    localparam int c_default_addr_w     = 12;
    localparam int c_default_data_w     = 8;
    localparam int c_default_fifo_depth = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_VGA = 2'd1,
        GRANT_CPU = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vram_wr_fifo
// Desc     : Synchronous write-buffer FIFO; full flag registered from next count.
// Revision : 1.0
// ============================================================================
module vram_wr_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [c_ptr_w:0]   w_count_next;
    logic               r_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_empty   = (r_count == '0);
    assign w_push    = push && !r_full;
    assign w_pop     = pop && !w_empty;
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = r_full;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // Full looks at the post-update count, so a popping cycle at full
            // still reports full and ready returns one cycle later.
            r_full  <= (w_count_next == c_depth);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Desc     : VGA-priority arbiter for single-port VRAM with buffered CPU writes.
//            Optional stall counter enabled by VRAM_ARB_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DATA_W     = c_default_data_w,
    parameter int FIFO_DEPTH = c_default_fifo_depth
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int c_entry_w = ADDR_W + DATA_W;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;

    grant_e               w_grant;
    grant_e               r_state;
    logic [c_entry_w-1:0] w_head;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 r_rd_valid;
    logic [DATA_W-1:0]    r_rd_data;

    assign w_fifo_empty = (w_fifo_count == '0);
    assign cpu_wr_ready = !w_fifo_full;
    assign w_push       = cpu_wr_en && cpu_wr_ready;
    assign w_pop        = (w_grant == GRANT_CPU);

    vram_wr_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (w_push),
        .push_data ({cpu_wr_addr, cpu_wr_data}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full)
    );

    // VGA always wins; writes only fill the holes in the fetch stream.
    always_comb begin
        w_grant = IDLE;
        if (vga_rd_req) begin
            w_grant = GRANT_VGA;
        end else if (!w_fifo_empty) begin
            w_grant = GRANT_CPU;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = w_head[DATA_W-1:0];
        case (w_grant)
            GRANT_VGA: begin
                mem_en   = 1'b1;
                mem_addr = vga_rd_addr;
            end
            GRANT_CPU: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = w_head[c_entry_w-1:DATA_W];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // The registered grant is the first read-pipeline stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_grant;
            r_rd_valid <= (r_state == GRANT_VGA);
            if (r_state == GRANT_VGA) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign vga_rd_valid = r_rd_valid;
    assign vga_rd_data  = r_rd_data;

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (cpu_wr_en && !cpu_wr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Desc     : Self-checking bench for vram_arbiter (table, directed, random).
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [11:0] cpu_wr_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic        cpu_wr_ready;
    logic        vga_rd_req = 1'b0;
    logic [11:0] vga_rd_addr = '0;
    logic        vga_rd_valid;
    logic [7:0]  vga_rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    vram_arbiter #(.ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .vga_rd_req   (vga_rd_req),
        .vga_rd_addr  (vga_rd_addr),
        .vga_rd_valid (vga_rd_valid),
        .vga_rd_data  (vga_rd_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef VRAM_ARB_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Single-port RAM with one-cycle read latency, preloaded on the first edge.
    logic [7:0] vram [0:4095];
    bit         ram_inited = 1'b0;
    always @(posedge clock) begin
        if (!ram_inited) begin
            for (int i = 0; i < 4096; i++) vram[i] <= init_val(i);
            ram_inited <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    // Reference model: pending writes in acceptance order, RAM image, due reads.
    typedef struct packed { logic [11:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int due; logic [7:0] data; } rd_t;
    wr_t        mq[$];
    rd_t        rq[$];
    logic [7:0] ram_m [0:4095];
    int         cyc = 0;
    int         stall_m = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic vreq; logic [11:0] vaddr; logic cen; logic [11:0] caddr; logic [7:0] cdata;
        logic x_en; logic x_we; logic [11:0] x_addr; logic [7:0] x_wdata;
        logic x_ready; logic x_valid; logic [7:0] x_rdata;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic vreq, input logic [11:0] vaddr, input logic cen,
                        input logic [11:0] caddr, input logic [7:0] cdata, output bit accepted);
        bit rdy, xen, xwe, xv;
        logic [11:0] xa;
        logic [7:0]  xd, xrd;
        @(negedge clock);
        vga_rd_req = vreq; vga_rd_addr = vaddr;
        cpu_wr_en = cen; cpu_wr_addr = caddr; cpu_wr_data = cdata;
        #1;
        rdy = (mq.size() != DEPTH);
        xen = 1'b0; xwe = 1'b0; xa = '0; xd = '0;
        if (vreq) begin
            xen = 1'b1; xa = vaddr;
        end else if (mq.size() != 0) begin
            xen = 1'b1; xwe = 1'b1; xa = mq[0].addr; xd = mq[0].data;
        end
        xv = 1'b0; xrd = '0;
        if (rq.size() != 0 && rq[0].due == cyc) begin
            xv = 1'b1; xrd = rq[0].data; void'(rq.pop_front());
        end
        chk("mem_en", 32'(mem_en), 32'(xen));
        chk("mem_we", 32'(mem_we), 32'(xwe));
        if (xen) chk("mem_addr", 32'(mem_addr), 32'(xa));
        if (xwe) chk("mem_wdata", 32'(mem_wdata), 32'(xd));
        chk("cpu_wr_ready", 32'(cpu_wr_ready), 32'(rdy));
        chk("vga_rd_valid", 32'(vga_rd_valid), 32'(xv));
        if (xv) chk("vga_rd_data", 32'(vga_rd_data), 32'(xrd));
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("stall_count", 32'(stall_count), 32'(stall_m));
`endif
        if (xwe) begin
            ram_m[xa] = xd;
            void'(mq.pop_front());
        end
        if (vreq) rq.push_back('{due: cyc + 2, data: ram_m[vaddr]});
        accepted = cen && rdy;
        if (accepted) mq.push_back('{addr: caddr, data: cdata});
        if (cen && !rdy && stall_m < 65535) stall_m++;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        vga_rd_req = 1'b0; vga_rd_addr = '0;
        cpu_wr_en = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        #1;
        chk("rst_ready", 32'(cpu_wr_ready), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_valid", 32'(vga_rd_valid), 32'd0);
        chk("rst_rdata", 32'(vga_rd_data), 32'd0);
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("rst_stall", 32'(stall_count), 32'd0);
`endif
        mq.delete();
        rq.delete();
        stall_m = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, '0, a);
    endtask

    initial begin
        bit          acc;
        int          nw, we_seen, vcnt, pct;
        bit          pend_c;
        logic [11:0] ca;
        logic [7:0]  cd;

        for (int i = 0; i < 4096; i++) ram_m[i] = init_val(i);

        tbl[0] = '{1'b0, 12'h000, 1'b1, 12'h055, 8'hA7, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 12'h055, 8'hA7, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 12'h055, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h055, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 8'hA7};
        tbl[5] = '{1'b1, 12'h123, 1'b1, 12'h123, 8'h5C, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 12'h123, 8'h5C, 1'b1, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 12'h123, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b1, 8'h14};
        tbl[8] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[9] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 8'h5C};

        // Reset, then idle
        apply_reset();
        idle(10);

        // Single write / read-back / contention table
        for (int r = 0; r < 10; r++) begin
            tick(tbl[r].vreq, tbl[r].vaddr, tbl[r].cen, tbl[r].caddr, tbl[r].cdata, acc);
            chk("tbl_en", 32'(mem_en), 32'(tbl[r].x_en));
            chk("tbl_we", 32'(mem_we), 32'(tbl[r].x_we));
            if (tbl[r].x_en) chk("tbl_addr", 32'(mem_addr), 32'(tbl[r].x_addr));
            if (tbl[r].x_we) chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[r].x_wdata));
            chk("tbl_ready", 32'(cpu_wr_ready), 32'(tbl[r].x_ready));
            chk("tbl_valid", 32'(vga_rd_valid), 32'(tbl[r].x_valid));
            if (tbl[r].x_valid) chk("tbl_rdata", 32'(vga_rd_data), 32'(tbl[r].x_rdata));
        end

        // Priority: VGA held for 20 cycles while the CPU tries 6 writes
        nw = 0; we_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 12'($urandom_range(0, 63)), nw < 6, 12'(12'h200 + nw), 8'(8'hC0 + nw), acc);
            if (mem_we) we_seen++;
            if (acc) nw++;
        end
        chk("prio_accepted", 32'(nw), 32'd4);
        chk("prio_we_seen", 32'(we_seen), 32'd0);
        chk("prio_ready_low", 32'(cpu_wr_ready), 32'd0);
        for (int d = 0; d < 4; d++) begin
            tick(1'b0, '0, nw < 6, 12'(12'h200 + nw), 8'(8'hC0 + nw), acc);
            chk("drain_we", 32'(mem_we), 32'd1);
            chk("drain_addr", 32'(mem_addr), 32'(12'h200 + d));
            if (d == 0) chk("ready_low_on_pop", 32'(cpu_wr_ready), 32'd0);
            if (d == 1) chk("ready_rises", 32'(cpu_wr_ready), 32'd1);
            if (acc) nw++;
        end
        for (int d = 0; d < 8; d++) begin
            tick(1'b0, '0, nw < 6, 12'(12'h200 + nw), 8'(8'hC0 + nw), acc);
            if (acc) nw++;
        end
        idle(2);

        // Simultaneous push/pop at count 2 across the pointer wrap
        for (int k = 0; k < 2; k++) tick(1'b1, 12'h010, 1'b1, 12'(12'h300 + k), 8'(8'h30 + k), acc);
        for (int k = 2; k < 9; k++) begin
            tick(1'b0, '0, 1'b1, 12'(12'h300 + k), 8'(8'h30 + k), acc);
            chk("pp_ready", 32'(cpu_wr_ready), 32'd1);
            chk("pp_pop_addr", 32'(mem_addr), 32'(12'h300 + k - 2));
            chk("pp_pop_data", 32'(mem_wdata), 32'(8'h30 + k - 2));
        end
        tick(1'b1, 12'h300, 1'b0, '0, '0, acc);
        idle(4);
        tick(1'b1, 12'h308, 1'b0, '0, '0, acc);
        idle(3);

        // Back-to-back reads 0x000..0x007
        vcnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick(t < 8, 12'(t), 1'b0, '0, '0, acc);
            if (t >= 2 && vga_rd_valid) vcnt++;
        end
        chk("b2b_valid_count", 32'(vcnt), 32'd8);

        // Reset mid-drain with 3 buffered writes and a read in flight
        for (int k = 0; k < 3; k++) tick(1'b1, 12'h020, 1'b1, 12'(12'h400 + k), 8'(8'h40 + k), acc);
        tick(1'b1, 12'h021, 1'b1, 12'h7FF, 8'hEE, acc);
        apply_reset();
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, '0, 1'b0, '0, '0, acc);
            if (mem_we) we_seen++;
        end
        chk("midrst_no_we", 32'(we_seen), 32'd0);
        chk("midrst_ready", 32'(cpu_wr_ready), 32'd1);

        // Randomized traffic with varying blanking density
        pend_c = 1'b0; ca = '0; cd = '0; pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) pct = int'($urandom_range(5, 95));
            if (!pend_c && $urandom_range(0, 99) < 45) begin
                pend_c = 1'b1;
                ca = 12'($urandom_range(0, 63));
                cd = 8'($urandom);
            end
            tick($urandom_range(0, 99) < pct, 12'($urandom_range(0, 63)), pend_c, ca, cd, acc);
            if (acc) pend_c = 1'b0;
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
